display_decoder: RTL and testbench

Registered seven-segment glyph decoder. It turns a 4-bit code into an 8-bit segment pattern, selecting either a numeric/hex glyph set or a 16-entry letter glyph set. It sits between the display data path (counters, status registers) and the scanned seven-segment display driver. The output is registered once, so segment lines are glitch-free.

---
 rtl/display_pkg.sv | 22 ++
 rtl/seg_glyph_rom.sv | 19 +
 rtl/display_decoder.sv | 50 +++++
 tb/tb_display_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph tables for the seven-segment display decoder.
// Glyphs are stored active-high as {g,f,e,d,c,b,a}.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;
    localparam int unsigned DP_BIT = 7;

    // 0-9 then A b C d E F
    localparam seg_t NUM_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // A b C d E F G H I J L n o P r U
    localparam seg_t LTR_GLYPHS [16] = '{
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,
        7'h30, 7'h1E, 7'h38, 7'h54, 7'h5C, 7'h73, 7'h50, 7'h3E
    };

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph lookup: 4-bit code plus set select to active-high segments.
module seg_glyph_rom
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       ltr_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (ltr_i) begin
            seg_o = LTR_GLYPHS[code_i];
        end else begin
            seg_o = NUM_GLYPHS[code_i];
        end
    end

endmodule

// File: rtl/display_decoder.sv
// Registered seven-segment decoder: glyph lookup, blank/dp merge, polarity,
// and a single async-reset output register so segment lines never glitch.
module display_decoder
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] data_i,
    input  logic       ltr_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] AllOff = ACTIVE_LOW ? 8'hFF : 8'h00;

    seg_t       glyph;
    logic [7:0] pattern_hi;
    logic [7:0] seg_d;
    logic [7:0] seg_q;

    seg_glyph_rom u_rom (
        .code_i (data_i),
        .ltr_i  (ltr_i),
        .seg_o  (glyph)
    );

    always_comb begin
        pattern_hi = 8'h00;
        if (!blank_i) begin
            pattern_hi[6:0]    = glyph;
            pattern_hi[DP_BIT] = dp_i;
        end
        // Polarity is applied last so blank maps to all-off on either board.
        seg_d = ACTIVE_LOW ? ~pattern_hi : pattern_hi;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q <= AllOff;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign data_o = seg_q;

endmodule

// File: tb/tb_display_decoder.sv
// Self-checking bench for display_decoder: directed vectors, reset corners, and
// random stimulus against a table-based model, on both polarities.
module tb_display_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] data;
    logic       ltr;
    logic       dp;
    logic       blank;
    logic [7:0] out_al;
    logic [7:0] out_ah;

    int checks;
    int errors;

    display_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data),
        .ltr_i   (ltr),
        .dp_i    (dp),
        .blank_i (blank),
        .data_o  (out_al)
    );

    display_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data),
        .ltr_i   (ltr),
        .dp_i    (dp),
        .blank_i (blank),
        .data_o  (out_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model source: the board-level active-low bytes with dp off.
    logic [7:0] num_low [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic [7:0] ltr_low [16] = '{
        8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h89,
        8'hCF, 8'hE1, 8'hC7, 8'hAB, 8'hA3, 8'h8C, 8'hAF, 8'hC1
    };

    function automatic logic [7:0] model(input bit al, input bit l, input logic [3:0] c,
                                         input bit d, input bit b);
        logic [7:0] v;
        if (b) begin
            v = 8'hFF;
        end else begin
            v = l ? ltr_low[c] : num_low[c];
            if (d) v = v & 8'h7F;
        end
        return al ? v : ~v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Leaves time 1 after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] data;
        bit         ltr;
        bit         dp;
        bit         blank;
        logic [7:0] exp_al;
        logic [7:0] exp_ah;
    } vec_t;

    vec_t vecs [$];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        data   = 4'd8;
        ltr    = 1'b0;
        dp     = 1'b0;
        blank  = 1'b0;

        // Async reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_al_noclk", out_al, 8'hFF);
        chk("reset_ah_noclk", out_ah, 8'h00);
        step();
        step();
        chk("reset_al_held", out_al, 8'hFF);
        rst_n = 1'b1;
        #1;
        chk("reset_al_released_noedge", out_al, 8'hFF);
        step();
        chk("reset_first_load_al", out_al, 8'h80);
        chk("reset_first_load_ah", out_ah, 8'h7F);

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{4'(i), 1'b0, 1'b0, 1'b0, num_low[i], ~num_low[i]});
        end
        vecs.push_back('{4'd5,  1'b1, 1'b0, 1'b0, 8'h8E, 8'h71});
        vecs.push_back('{4'd10, 1'b1, 1'b0, 1'b0, 8'hC7, 8'h38});
        vecs.push_back('{4'd15, 1'b1, 1'b0, 1'b0, 8'hC1, 8'h3E});
        vecs.push_back('{4'd5,  1'b0, 1'b0, 1'b0, 8'h92, 8'h6D});
        vecs.push_back('{4'd5,  1'b1, 1'b0, 1'b0, 8'h8E, 8'h71});
        vecs.push_back('{4'd3,  1'b0, 1'b1, 1'b0, 8'h30, 8'hCF});
        vecs.push_back('{4'd3,  1'b0, 1'b1, 1'b1, 8'hFF, 8'h00});
        vecs.push_back('{4'd3,  1'b0, 1'b1, 1'b0, 8'h30, 8'hCF});
        vecs.push_back('{4'd7,  1'b1, 1'b1, 1'b0, 8'h09, 8'hF6});
        vecs.push_back('{4'd9,  1'b1, 1'b0, 1'b1, 8'hFF, 8'h00});

        for (int i = 0; i < vecs.size(); i++) begin
            data  = vecs[i].data;
            ltr   = vecs[i].ltr;
            dp    = vecs[i].dp;
            blank = vecs[i].blank;
            #1;
            // Combinational input change must not reach the output before the edge.
            if (i > 0) chk($sformatf("vec%0d_hold_al", i), out_al, vecs[i-1].exp_al);
            step();
            chk($sformatf("vec%0d_al", i), out_al, vecs[i].exp_al);
            chk($sformatf("vec%0d_ah", i), out_ah, vecs[i].exp_ah);
        end

        // Mid-stream reset pulse between edges discards the pending glyph.
        data = 4'd8; ltr = 1'b0; dp = 1'b0; blank = 1'b0;
        step();
        chk("mid_pre_al", out_al, 8'h80);
        data = 4'd2;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_al", out_al, 8'hFF);
        chk("mid_reset_ah", out_ah, 8'h00);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_released_al", out_al, 8'hFF);
        step();
        chk("mid_reload_al", out_al, 8'hA4);
        chk("mid_reload_ah", out_ah, 8'h5B);

        // Random stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            bit l, d, b;
            c = 4'($urandom_range(0, 15));
            l = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 7) == 0);
            data = c; ltr = l; dp = d; blank = b;
            step();
            chk($sformatf("rand%0d_al", i), out_al, model(1'b1, l, c, d, b));
            chk($sformatf("rand%0d_ah", i), out_ah, model(1'b0, l, c, d, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
